// File: rtl/disp_pkg.sv
// Shared display constants: blank pattern, hex-to-7-segment table and width helpers.
package disp_pkg;

   // All segments off on a common-anode display (active-low).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Width of the digit scan index for a given digit count.
   function automatic int idx_width(input int digits);
      return $clog2(digits);
   endfunction

   // Width of the history fill count, which must hold 0..digits.
   function automatic int fill_width(input int digits);
      return $clog2(digits + 1);
   endfunction

   // Widths for the default 4-digit display.
   localparam int IDX_W_DEF  = 2;
   localparam int FILL_W_DEF = 3;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational 4-bit value to active-low 7-segment pattern lookup.
module hex_to_seg
   import disp_pkg::*;
(
   input  logic [3:0] val_i,
   output logic [6:0] seg_o
);

   assign seg_o = HEX7_TABLE[val_i];

endmodule

// File: rtl/result_display_scanner.sv
// Keeps the last DIGITS ALU results and scans them onto a multiplexed
// common-anode 7-segment display; digit 0 always shows the newest result.
module result_display_scanner
   import disp_pkg::*;
#(
   parameter int CLK_DIV = 100000,
   parameter int DIGITS  = 4,
   parameter int DATA_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clear,
   input  logic              result_valid,
   input  logic [DATA_W-1:0] result_in,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic [2:0]        fill
);

   localparam int PRE_W  = $clog2(CLK_DIV);
   localparam int IDX_W  = idx_width(DIGITS);
   localparam int FILL_W = fill_width(DIGITS);

   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [DATA_W-1:0] hist_q [DIGITS];
   logic [DATA_W-1:0] hist_d [DIGITS];
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              tick;
   logic              lit;
   logic [6:0]        hex_seg;

   // Decode the history entry currently selected by the scan index.
   hex_to_seg u_hex_to_seg (
      .val_i (hist_q[idx_q]),
      .seg_o (hex_seg)
   );

   // Prescaler, scan index and history next-state.
   always_comb begin
      tick  = (pre_q == PRE_W'(CLK_DIV - 1));
      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = idx_q;
      if (tick)
         idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;

      fill_d = fill_q;
      for (int i = 0; i < DIGITS; i++)
         hist_d[i] = hist_q[i];
      // Clear has priority over a coincident capture.
      if (clear) begin
         fill_d = '0;
         for (int i = 0; i < DIGITS; i++)
            hist_d[i] = '0;
      end else if (result_valid) begin
         hist_d[0] = result_in;
         for (int i = 1; i < DIGITS; i++)
            hist_d[i] = hist_q[i-1];
         if (fill_q != FILL_W'(DIGITS))
            fill_d = fill_q + 1'b1;
      end
   end

   // Display drive derived from the pre-edge index, history and fill.
   always_comb begin
      lit   = (FILL_W'(idx_q) < fill_q);
      an_d  = lit ? ~(DIGITS'(1) << idx_q) : '1;
      seg_d = lit ? hex_seg : SEG_BLANK;
      dp_d  = !((idx_q == '0) && (fill_q != '0));
   end

   // State and output registers; en low freezes everything.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q  <= '0;
         idx_q  <= '0;
         fill_q <= '0;
         for (int i = 0; i < DIGITS; i++)
            hist_q[i] <= '0;
         seg_q  <= SEG_BLANK;
         dp_q   <= 1'b1;
         an_q   <= '1;
      end else if (en) begin
         pre_q  <= pre_d;
         idx_q  <= idx_d;
         fill_q <= fill_d;
         for (int i = 0; i < DIGITS; i++)
            hist_q[i] <= hist_d[i];
         seg_q  <= seg_d;
         dp_q   <= dp_d;
         an_q   <= an_d;
      end
   end

   assign seg  = seg_q;
   assign dp   = dp_q;
   assign an   = an_q;
   // The fill port is 3 bits; counts above 7 (DIGITS=8 when full) do not fit.
   assign fill = 3'(fill_q);

endmodule

// File: tb/tb_result_display_scanner.sv
// Directed bench for result_display_scanner with CLK_DIV=4, DIGITS=4.
module tb_result_display_scanner;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b1;
   logic       clear = 1'b0;
   logic       result_valid = 1'b0;
   logic [3:0] result_in = 4'h0;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic [2:0] fill;

   int checks = 0;
   int failures = 0;

   result_display_scanner #(.CLK_DIV(4), .DIGITS(4), .DATA_W(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clear        (clear),
      .result_valid (result_valid),
      .result_in    (result_in),
      .seg          (seg),
      .dp           (dp),
      .an           (an),
      .fill         (fill)
   );

   always #5 clk = ~clk;

   // At most one anode may be low in any cycle.
   always @(negedge clk) begin
      checks++;
      if ($countones(~an) > 1) begin
         failures++;
         $display("FAIL ghost: an=%b has more than one low bit", an);
      end
   end

   // Wait (bounded) until the anode pattern equals pat, sampling on negedge.
   task automatic wait_an(input logic [3:0] pat, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (an === pat) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic capture(input logic [3:0] v);
      result_valid = 1'b1;
      result_in    = v;
      @(negedge clk);
      result_valid = 1'b0;
   endtask

   task automatic test_reset;
      int bad;
      repeat (2) @(negedge clk);
      checks++;
      if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || fill !== 3'd0) begin
         failures++;
         $display("FAIL reset_state: seg=%h an=%h dp=%b fill=%0d required seg=7f an=f dp=1 fill=0",
                  seg, an, dp, fill);
      end
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (an !== 4'hF || seg !== 7'h7F) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL reset_idle_dark: %0d lit cycles, required 0", bad);
      end
   endtask

   task automatic test_capture;
      bit ok;
      result_valid = 1'b1; result_in = 4'h3;
      @(negedge clk); result_in = 4'hA;
      @(negedge clk); result_in = 4'h7;
      @(negedge clk); result_valid = 1'b0;
      checks++;
      if (fill !== 3'd3) begin
         failures++;
         $display("FAIL cap_fill: fill=%0d required 3", fill);
      end
      wait_an(4'b1110, ok);
      checks++;
      if (!ok || seg !== 7'h78 || dp !== 1'b0) begin
         failures++;
         $display("FAIL cap_digit0: found=%b seg=%h dp=%b required seg=78 dp=0", ok, seg, dp);
      end
      wait_an(4'b1101, ok);
      checks++;
      if (!ok || seg !== 7'h08 || dp !== 1'b1) begin
         failures++;
         $display("FAIL cap_digit1: found=%b seg=%h dp=%b required seg=08 dp=1", ok, seg, dp);
      end
      wait_an(4'b1011, ok);
      checks++;
      if (!ok || seg !== 7'h30) begin
         failures++;
         $display("FAIL cap_digit2: found=%b seg=%h required seg=30", ok, seg);
      end
      wait_an(4'b1111, ok);
      checks++;
      if (!ok || seg !== 7'h7F || dp !== 1'b1) begin
         failures++;
         $display("FAIL cap_digit3_blank: found=%b seg=%h dp=%b required seg=7f dp=1", ok, seg, dp);
      end
   endtask

   task automatic test_saturate;
      bit ok;
      logic [6:0] exp_seg [4] = '{7'h02, 7'h12, 7'h19, 7'h30};
      for (int v = 1; v <= 6; v++) capture(4'(v));
      checks++;
      if (fill !== 3'd4) begin
         failures++;
         $display("FAIL sat_fill: fill=%0d required 4", fill);
      end
      for (int d = 0; d < 4; d++) begin
         wait_an(~(4'b0001 << d), ok);
         checks++;
         if (!ok || seg !== exp_seg[d]) begin
            failures++;
            $display("FAIL sat_digit%0d: found=%b seg=%h required %h", d, ok, seg, exp_seg[d]);
         end
      end
   endtask

   task automatic test_clear;
      bit ok;
      int bad;
      clear = 1'b1; result_valid = 1'b1; result_in = 4'h9;
      @(negedge clk);
      clear = 1'b0; result_valid = 1'b0;
      checks++;
      if (fill !== 3'd0) begin
         failures++;
         $display("FAIL clear_fill: fill=%0d required 0", fill);
      end
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 17; i++) begin
         if (an !== 4'hF || seg !== 7'h7F) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL clear_dark: %0d lit cycles, required 0", bad);
      end
      capture(4'h5);
      checks++;
      if (fill !== 3'd1) begin
         failures++;
         $display("FAIL clear_refill: fill=%0d required 1", fill);
      end
      wait_an(4'b1110, ok);
      checks++;
      if (!ok || seg !== 7'h12 || dp !== 1'b0) begin
         failures++;
         $display("FAIL clear_digit0: found=%b seg=%h dp=%b required seg=12 dp=0", ok, seg, dp);
      end
   endtask

   task automatic test_enable_freeze;
      bit ok;
      int n;
      logic [3:0] an0;
      logic [6:0] seg0;
      logic       dp0;
      logic [2:0] fill0;
      // Refill: history becomes d,C,9,8 from newest to oldest.
      capture(4'h8); capture(4'h9); capture(4'hC); capture(4'hD);
      an0 = an;
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (an !== an0) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL freeze_sync: no anode change within 10 cycles, required one");
      end
      repeat (2) @(negedge clk);
      en = 1'b0; result_valid = 1'b1; result_in = 4'hF;
      an0 = an; seg0 = seg; dp0 = dp; fill0 = fill;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (an !== an0 || seg !== seg0 || dp !== dp0 || fill !== fill0) begin
            failures++;
            $display("FAIL freeze_hold cycle %0d: an=%h seg=%h dp=%b fill=%0d required an=%h seg=%h dp=%b fill=%0d",
                     i, an, seg, dp, fill, an0, seg0, dp0, fill0);
         end
      end
      en = 1'b1; result_valid = 1'b0;
      n = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (an !== an0) begin n = i; break; end
      end
      checks++;
      if (n !== 2) begin
         failures++;
         $display("FAIL freeze_resume: anode changed after %0d cycles, required 2", n);
      end
      wait_an(4'b1110, ok);
      checks++;
      if (!ok || seg !== 7'h21 || fill !== 3'd4) begin
         failures++;
         $display("FAIL freeze_no_capture: found=%b seg=%h fill=%0d required seg=21 fill=4", ok, seg, fill);
      end
   endtask

   task automatic test_reset_mid_scan;
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (seg !== 7'h7F || an !== 4'hF || dp !== 1'b1 || fill !== 3'd0) begin
         failures++;
         $display("FAIL async_reset: seg=%h an=%h dp=%b fill=%0d required seg=7f an=f dp=1 fill=0",
                  seg, an, dp, fill);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      capture(4'h1);
      @(negedge clk);
      checks++;
      if (an !== 4'b1110 || seg !== 7'h79 || dp !== 1'b0 || fill !== 3'd1) begin
         failures++;
         $display("FAIL reset_restart_idx0: an=%b seg=%h dp=%b fill=%0d required an=1110 seg=79 dp=0 fill=1",
                  an, seg, dp, fill);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_saturate();
      test_clear();
      test_enable_freeze();
      test_reset_mid_scan();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
